// File: rtl/des_final_perm_serializer.sv
// ============================================================================
// Module      : des_final_perm_serializer
// Description : DES output stage. Applies the 32-bit swap and IP^-1, buffers
//               ciphertext words and serializes them as bytes (valid/ready).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module des_final_perm_serializer #(
    parameter int FIFO_DEPTH = 2,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] l16,
    input  logic [31:0] r16,
    output logic [63:0] ct_out,
    output logic        ct_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        drop_err
);

    localparam int             c_aw    = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0]  c_depth = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [0:0]     c_idle  = 1'b0;
    localparam logic [0:0]     c_send  = 1'b1;

    logic [63:0]     w_preout;
    logic [63:0]     w_perm;
    logic [63:0]     w_shift_next;
    logic            w_push;
    logic            w_pop;
    logic            w_frame_end;

    logic [63:0]     r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic [0:0]      r_state;
    logic [63:0]     r_shift;
    logic [2:0]      r_byte_cnt;
    logic [63:0]     r_ct_out;
    logic            r_ct_valid;
    logic            r_drop_err;

    assign w_preout = {r16, l16};

    // IP^-1 source bit for output position i: even columns read 40-row+8k,
    // odd columns read 8-row+8k (FIPS 46-3 table, 1 = MSB numbering).
    generate
        for (genvar gi = 1; gi <= 64; gi++) begin : g_perm
            localparam int c_row = (gi - 1) / 8;
            localparam int c_col = (gi - 1) % 8;
            localparam int c_src = ((c_col % 2) == 0) ? (40 - c_row + 8 * (c_col / 2))
                                                      : (8 - c_row + 8 * (c_col / 2));
            assign w_perm[64 - gi] = w_preout[64 - c_src];
        end
    endgenerate

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign tx_data      = r_shift[63:56];
            assign w_shift_next = {r_shift[55:0], 8'h00};
        end else begin : g_lsb_first
            assign tx_data      = r_shift[7:0];
            assign w_shift_next = {8'h00, r_shift[63:8]};
        end
    endgenerate

    // Readiness looks only at the registered count, so a same-cycle pop never frees a slot.
    assign in_ready    = (r_count != c_depth);
    assign w_push      = in_valid && in_ready;
    assign w_frame_end = (r_state == c_send) && tx_ready && (r_byte_cnt == 3'd7);
    assign w_pop       = (r_count != '0) && ((r_state == c_idle) || w_frame_end);

    assign tx_valid = (r_state == c_send);
    assign busy     = (r_count != '0) || (r_state == c_send);
    assign ct_out   = r_ct_out;
    assign ct_valid = r_ct_valid;
    assign drop_err = r_drop_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_perm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_state    <= c_idle;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_ct_out   <= '0;
            r_ct_valid <= 1'b0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            r_ct_valid <= w_push;
            if (w_push) begin
                r_ct_out <= w_perm;
            end
            if (in_valid && !in_ready) begin
                r_drop_err <= 1'b1;
            end

            if (w_pop) begin
                r_shift    <= r_mem[r_rd_ptr];
                r_byte_cnt <= 3'd0;
                r_state    <= c_send;
            end else if ((r_state == c_send) && tx_ready) begin
                r_shift    <= w_shift_next;
                r_byte_cnt <= r_byte_cnt + 3'd1;
                if (r_byte_cnt == 3'd7) begin
                    r_state <= c_idle;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_des_final_perm_serializer.sv
// ============================================================================
// Module      : tb_des_final_perm_serializer
// Description : Scoreboard bench for des_final_perm_serializer (MSB- and
//               LSB-first builds driven in lockstep).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_des_final_perm_serializer;

    localparam int FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] l16 = '0;
    logic [31:0] r16 = '0;

    logic        in_ready, ct_valid, tx_valid, busy, drop_err;
    logic [63:0] ct_out;
    logic [7:0]  tx_data;
    logic        in_ready_l, ct_valid_l, tx_valid_l, busy_l, drop_err_l;
    logic [63:0] ct_out_l;
    logic [7:0]  tx_data_l;

    des_final_perm_serializer #(.FIFO_DEPTH(FIFO_DEPTH), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .l16(l16), .r16(r16), .ct_out(ct_out), .ct_valid(ct_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .drop_err(drop_err)
    );

    des_final_perm_serializer #(.FIFO_DEPTH(FIFO_DEPTH), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
        .l16(l16), .r16(r16), .ct_out(ct_out_l), .ct_valid(ct_valid_l),
        .tx_data(tx_data_l), .tx_valid(tx_valid_l), .tx_ready(tx_ready),
        .busy(busy_l), .drop_err(drop_err_l)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_bytes = 0;
    logic        rand_ready = 1'b0;
    logic        fixed_ready = 1'b0;
    logic [7:0]  q_msb [$];
    logic [7:0]  q_lsb [$];
    logic [63:0] q_ct [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Forward initial permutation (input-side model), 1 = MSB numbering.
    function automatic logic [63:0] ip_fwd(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 1; i <= 64; i++) begin
            int r;
            int c;
            int src;
            r   = (i - 1) / 8;
            c   = (i - 1) % 8;
            src = (r < 4) ? (58 + 2 * r - 8 * c) : (57 + 2 * (r - 4) - 8 * c);
            y[64 - i] = x[64 - src];
        end
        return y;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [63:0] x, input logic exp_acc, input logic [63:0] ip_in);
        {r16, l16} = ip_in;
        in_valid   = 1'b1;
        check("in_ready", in_ready, exp_acc);
        if (exp_acc) begin
            q_ct.push_back(x);
            for (int k = 0; k < 8; k++) begin
                q_msb.push_back(x[63 - 8 * k -: 8]);
                q_lsb.push_back(x[8 * k +: 8]);
            end
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int t = 0; t < budget && (busy || busy_l || q_msb.size() != 0); t++) begin
            step();
        end
        check("drain_busy", busy, 1'b0);
        check("drain_q", q_msb.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
        end
    end

    // Output monitor: byte/ct scoreboard plus hold-while-stalled checks.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [63:0] exp_ct;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", tx_valid, 1'b1);
                    check("hold_data", tx_data, prev_data);
                end
                if (tx_valid && tx_ready) begin
                    check("byte_expected", q_msb.size() != 0, 1'b1);
                    if (q_msb.size() != 0) check("tx_byte", tx_data, q_msb.pop_front());
                    n_bytes++;
                end
                if (tx_valid_l && tx_ready) begin
                    check("byte_expected_lsb", q_lsb.size() != 0, 1'b1);
                    if (q_lsb.size() != 0) check("tx_byte_lsb", tx_data_l, q_lsb.pop_front());
                end
                if (ct_valid) begin
                    check("ct_expected", q_ct.size() != 0, 1'b1);
                    if (q_ct.size() != 0) begin
                        exp_ct = q_ct.pop_front();
                        check("ct_out", ct_out, exp_ct);
                        check("ct_valid_lsb", ct_valid_l, 1'b1);
                        check("ct_out_lsb", ct_out_l, exp_ct);
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] x;
        logic [63:0] fips_ct;
        logic [63:0] fips_in;
        int          run;
        fips_ct = 64'h85E813540F0AB405;
        fips_in = {32'h0A4CD995, 32'h43423234};

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_ct_out", ct_out, 64'h0);
        check("rst_ct_valid", ct_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_drop_err", drop_err, 1'b0);
        rst = 1'b0;
        fixed_ready = 1'b1;
        step();
        step();

        // FIPS vector with exact latency
        push_word(fips_ct, 1'b1, fips_in);
        check("lat_ct_valid_n1", ct_valid, 1'b1);
        check("lat_tx_valid_n1", tx_valid, 1'b0);
        step();
        for (int k = 0; k < 8; k++) begin
            check("fips_tx_valid", tx_valid, 1'b1);
            check("fips_byte", tx_data, fips_ct[63 - 8 * k -: 8]);
            check("fips_byte_lsb", tx_data_l, fips_ct[8 * k +: 8]);
            step();
        end
        check("fips_end_valid", tx_valid, 1'b0);
        check("fips_end_busy", busy, 1'b0);

        // Round trip with random backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            x = {$urandom, $urandom};
            for (int t = 0; t < 100 && !in_ready; t++) step();
            push_word(x, 1'b1, ip_fwd(x));
        end
        wait_drain(2000);
        rand_ready  = 1'b0;
        fixed_ready = 1'b0;
        step();

        // Full FIFO and drop
        n_bytes = 0;
        for (int n = 0; n < 3; n++) begin
            x = {$urandom, $urandom};
            push_word(x, 1'b1, ip_fwd(x));
        end
        x = {$urandom, $urandom};
        push_word(x, 1'b0, ip_fwd(x));
        check("drop_err_set", drop_err, 1'b1);
        repeat (5) step();
        check("drop_err_sticky", drop_err, 1'b1);
        fixed_ready = 1'b1;
        wait_drain(200);
        check("drop_bytes", n_bytes, 24);
        check("drop_err_after", drop_err, 1'b1);

        // Back-to-back frames
        for (int n = 0; n < 2; n++) begin
            x = {$urandom, $urandom};
            push_word(x, 1'b1, ip_fwd(x));
        end
        run = 0;
        while (tx_valid && run < 40) begin
            run++;
            step();
        end
        check("b2b_run", run, 16);
        check("b2b_busy_fall", busy, 1'b0);

        // Reset mid-frame
        push_word(fips_ct, 1'b1, fips_in);
        step();
        repeat (3) step();
        rst = 1'b1;
        step();
        check("mid_rst_tx_valid", tx_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_drop_err", drop_err, 1'b0);
        q_msb.delete();
        q_lsb.delete();
        q_ct.delete();
        rst = 1'b0;
        n_bytes = 0;
        repeat (20) step();
        check("mid_rst_no_bytes", n_bytes, 0);
        check("mid_rst_idle", tx_valid_l, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
